// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file definitions: datapath widths and writeback source encoding.
package rf_wb_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small load-writeback queue; the head is visible combinationally on dout.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU vs queued loads, registered RF write port, busy scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = rf_wb_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_wb_arbiter_pkg::ADDR_WIDTH,
  parameter int MQ_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_waddr,
  input  logic [DATA_WIDTH-1:0]    alu_wdata,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_WIDTH-1:0]    mem_waddr,
  input  logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_waddr,
  output logic                     iss_ready,
  output logic [2**ADDR_WIDTH-1:0] busy
);
  localparam int NREG = 2**ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  wb_req_t   mem_req, head, alu_req, sel;
  logic      full, empty, push, gnt_alu, gnt_mem;
  wb_src_e   last;
  logic [NREG-1:0] busy_q, busy_d;

  assign mem_req = '{waddr: mem_waddr, wdata: mem_wdata};
  assign alu_req = '{waddr: alu_waddr, wdata: alu_wdata};
  assign push    = mem_valid && !full;

  wb_fifo #(.W($bits(wb_req_t)), .DEPTH(MQ_DEPTH)) u_mq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (gnt_mem),
    .din   (mem_req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A full queue with another load waiting jumps the round-robin order.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (rst_n) begin
      if (full && mem_valid)       gnt_mem = 1'b1;
      else if (alu_valid && !empty) begin
        if (last == SRC_ALU)       gnt_mem = 1'b1;
        else                       gnt_alu = 1'b1;
      end
      else if (alu_valid)          gnt_alu = 1'b1;
      else if (!empty)             gnt_mem = 1'b1;
    end
  end

  assign sel       = gnt_mem ? head : alu_req;
  assign alu_ready = gnt_alu;
  assign mem_ready = !full;

  // x0 grants retire silently: no write, output fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      last     <= SRC_ALU;
    end else begin
      rf_wen <= 1'b0;
      if (gnt_alu || gnt_mem) begin
        last <= gnt_mem ? SRC_MEM : SRC_ALU;
        if (sel.waddr != '0) begin
          rf_wen   <= 1'b1;
          rf_waddr <= sel.waddr;
          rf_wdata <= sel.wdata;
        end
      end
    end
  end

  assign iss_ready = (iss_waddr == '0) || !busy_q[iss_waddr];

  always_comb begin
    busy_d = busy_q;
    if (rf_wen) busy_d[rf_waddr] = 1'b0;
    if (iss_valid && iss_ready && iss_waddr != '0) busy_d[iss_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MQD  = 2;
  localparam int NR   = 2**AW;
  localparam int NCYC = 3000;
  localparam int NDRN = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_waddr, mem_waddr, rf_waddr, iss_waddr;
  logic [DW-1:0] alu_wdata, mem_wdata, rf_wdata;
  logic          rf_wen, iss_valid, iss_ready;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MQ_DEPTH(MQD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready), .busy(busy)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;

  // Reference model: load queue contents, reservations, last-served source, current RF write.
  wr_t           mq[$];
  wr_t           exp_q[$];
  logic [NR-1:0] m_busy;
  bit            m_last_mem;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_busy     = '0;
    m_last_mem = 1'b0;
    m_wen      = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x%0d=%0h expected no write at %0t", rf_waddr, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", rf_waddr, e.a);
        chk("wr_data", rf_wdata, e.d);
      end
    end
  end

  initial begin
    bit            m_full, m_head, g_alu, g_mem, exp_iss, did_rst, drain;
    logic [NR-1:0] nb;
    wr_t           w;

    rst_n = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h1234;
    mem_valid = 1'b0; mem_waddr = '0;   mem_wdata = '0;
    iss_valid = 1'b0; iss_waddr = '0;
    did_rst = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 0);
    alu_valid = 1'b0;
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC + NDRN; cyc++) begin
      drain = (cyc >= NCYC);
      @(negedge clk);
      m_full = (mq.size() == MQD);
      m_head = (mq.size() != 0);
      g_alu = 1'b0;
      g_mem = 1'b0;
      if (m_full && mem_valid)     g_mem = 1'b1;
      else if (alu_valid && m_head) begin
        if (m_last_mem) g_alu = 1'b1;
        else            g_mem = 1'b1;
      end
      else if (alu_valid)          g_alu = 1'b1;
      else if (m_head)             g_mem = 1'b1;
      exp_iss = (iss_waddr == 0) || !m_busy[iss_waddr];

      chk("alu_ready", alu_ready, g_alu);
      chk("mem_ready", mem_ready, !m_full);
      chk("iss_ready", iss_ready, exp_iss);
      chk("busy", busy, m_busy);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_waddr_hold", rf_waddr, m_waddr);
      chk("rf_wdata_hold", rf_wdata, m_wdata);

      if (!did_rst && !drain && cyc > 1000 && m_full && m_wen) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_wen", rf_wen, 0);
        chk("mid_rst_rf_waddr", rf_waddr, 0);
        chk("mid_rst_rf_wdata", rf_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_ready", mem_ready, 1);
        chk("mid_rst_alu_ready", alu_ready, 0);
        did_rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        continue;
      end

      @(posedge clk);
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (iss_valid && exp_iss && iss_waddr != 0) nb[iss_waddr] = 1'b1;
      m_busy = nb;

      m_wen = 1'b0;
      if (g_alu || g_mem) begin
        if (g_mem) w = mq.pop_front();
        else       w = '{alu_waddr, alu_wdata};
        m_last_mem = g_mem;
        if (w.a != 0) begin
          m_wen   = 1'b1;
          m_waddr = w.a;
          m_wdata = w.d;
          exp_q.push_back(w);
        end
      end
      if (mem_valid && !m_full) mq.push_back('{mem_waddr, mem_wdata});

      #1;
      if (!alu_valid || g_alu) begin
        alu_valid = !drain && ($urandom_range(0, 99) < 60);
        alu_waddr = AW'($urandom_range(0, 7));
        alu_wdata = $urandom;
      end
      if (!mem_valid || !m_full) begin
        mem_valid = !drain && ($urandom_range(0, 99) < 70);
        mem_waddr = AW'($urandom_range(0, 7));
        mem_wdata = $urandom;
      end
      iss_valid = !drain && ($urandom_range(0, 3) == 0);
      iss_waddr = AW'($urandom_range(0, 7));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("reset_case_reached", did_rst, 1);
    chk("drained_expected", exp_q.size(), 0);
    chk("drained_queue", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, register data width; ADDR_WIDTH, 5, register index width; MQ_DEPTH, 2, memory-writeback queue entries (power of two, >=2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 alu_valid / alu_ready  in / out  1 / 1  ALU writeback handshake.
REQ-006 alu_waddr / alu_wdata  in / in  ADDR_WIDTH / DATA_WIDTH  ALU destination register and value.
REQ-007 mem_valid / mem_ready  in / out  1 / 1  load writeback handshake.
REQ-008 mem_waddr / mem_wdata  in / in  ADDR_WIDTH / DATA_WIDTH  load destination register and value.
REQ-009 rf_wen / rf_waddr / rf_wdata  out / out / out  1 / ADDR_WIDTH / DATA_WIDTH  registered drive of the register-file write port.
REQ-010 iss_valid / iss_waddr  in / in  1 / ADDR_WIDTH  decode reserves a destination register.
REQ-011 iss_ready  out  1  reservation accepted this cycle.
REQ-012 busy  out  2**ADDR_WIDTH  per-register pending-write scoreboard; bit 0 is always 0.

Function
REQ-013 Transfer: valid&ready high at a rising edge; a requester SHALL hold valid, waddr and wdata stable until it sees ready.
REQ-014 Memory requests: pushed into an MQ_DEPTH FIFO (wb_fifo); mem_ready = !full, independent of mem_valid.
REQ-015 Per cycle, at most one source (ALU request or FIFO head) SHALL be granted to the output stage.
REQ-016 Arbitration: one contender wins alone; with both present, the source not granted last SHALL win (round-robin pointer updated on every grant).
REQ-017 Override: FIFO full with mem_valid high SHALL grant the FIFO head regardless of the pointer.
REQ-018 alu_ready SHALL be high iff the ALU is granted in that cycle.
REQ-019 Latency: ALU accepted at cycle N -> rf_wen high in N+1; load pushed into an empty FIFO at N -> popped no earlier than N+1 -> rf_wen in N+2.
REQ-020 Output: rf_wen is high for exactly one cycle per granted request, and only if its waddr != 0.
REQ-021 x0: a granted request with waddr = 0 completes its handshake and advances the pointer, with rf_wen low.
REQ-022 Output idle: rf_waddr/rf_wdata SHALL hold their last values while rf_wen is low.
REQ-023 Scoreboard set: iss_valid & iss_ready with iss_waddr != 0 sets busy[iss_waddr] at that edge.
REQ-024 iss_ready = !busy[iss_waddr] (1 when iss_waddr = 0); x0 is never reserved.
REQ-025 Scoreboard clear: busy[r] clears on the edge ending the cycle where rf_wen=1 and rf_waddr=r, i.e. busy is low from the next cycle.
REQ-026 Same-register set and clear in one cycle: iss_ready is 0 (busy still 1), so the set is refused and the clear wins.
REQ-027 Write to a non-busy register: performed normally; busy is unchanged (no underflow).
REQ-028 FIFO: simultaneous push and pop when full SHALL be refused (ready low); when empty, the pushed entry becomes the head next cycle.

Reset
REQ-029 rst_n low SHALL immediately force rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty (mem_ready=1), alu_ready=0, and pointer = ALU last-granted.
REQ-030 Reset mid-operation SHALL discard queued loads and the in-flight output write with no write issued; the first grant after release is legal in the first cycle that rst_n is high.

Structure
REQ-031 DATA_WIDTH, ADDR_WIDTH, and source encoding (SRC_ALU=0, SRC_MEM=1) SHALL live in the shared rf package/header used by the register-file datapath.
REQ-032 The memory queue SHALL be a sub-module wb_fifo (push/pop, full/empty, DEPTH parameter); the arbiter, output register and scoreboard SHALL remain in rf_wb_arbiter.

Verification
REQ-033 ALU only: alu (x5, 0x1234) at cycle 2 -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in cycle 3 only.
REQ-034 Contention: both valid (alu x3 = 0xA, mem x4 = 0xB) with pointer = ALU -> writes in order x4 then x3 on consecutive cycles, with alu_ready low in the first cycle.
REQ-035 Full FIFO: push 2 loads with no grant -> mem_ready=0; a third load waits until the first pop, and FIFO priority beats a pending ALU request.
REQ-036 Scoreboard: issue x7 -> busy[7]=1, iss_ready(x7)=0; ALU write x7 -> busy[7]=0 on the cycle after rf_wen; same-cycle re-issue of x7 is refused.
REQ-037 x0: alu_waddr=0, wdata=0xFFFF -> alu_ready=1, rf_wen stays 0, busy unchanged, pointer advances.
REQ-038 Reset: assert rst_n low with 2 loads queued and rf_wen=1 -> all outputs zero asynchronously, and no write occurs after release.
